// File: rtl/commit_store_buffer.sv
// Committed-store FIFO between the ROB commit port and data memory.
// Drains stores over req/ack and forwards the youngest matching store to loads.
module commit_store_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [31:0]       commit_addr,
  input  logic [31:0]       commit_data,
  input  logic [2:0]        commit_funct3,
  input  logic [31:0]       commit_inst_num,
  output logic              sb_full,
  output logic              sb_empty,
  output logic [PTR_W:0]    sb_count,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  output logic              drain_done,
  output logic [31:0]       drain_inst_num,
  input  logic [31:0]       ld_query_addr,
  output logic              ld_fwd_hit,
  output logic [31:0]       ld_fwd_data,
  output logic [3:0]        ld_fwd_strb,
  output logic              err_misalign,
  output logic              err_overflow
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:2]      ent_addr  [DEPTH];
  logic [31:0]      ent_wdata [DEPTH];
  logic [3:0]       ent_wstrb [DEPTH];
  logic [31:0]      ent_tag   [DEPTH];
  logic [DEPTH-1:0] valid;

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic        legal;
  logic [3:0]  fmt_strb;
  logic [31:0] fmt_data;
  logic        push, pop;
  logic [PTR_W-1:0] idx;
  logic        unused_ld_low;

  assign unused_ld_low = ^ld_query_addr[1:0];

  assign sb_full  = (count == CNT_W'(DEPTH));
  assign sb_empty = (count == '0);
  assign sb_count = count;

  assign mem_req   = !sb_empty;
  assign mem_addr  = {ent_addr[head], 2'b00};
  assign mem_wdata = ent_wdata[head];
  assign mem_wstrb = ent_wstrb[head];

  assign push = commit_valid && legal && !sb_full;
  assign pop  = mem_req && mem_ack;

  // Alignment check and byte-lane replication of the committed store
  always_comb begin
    legal    = 1'b0;
    fmt_strb = 4'b0000;
    fmt_data = 32'h0;
    case (commit_funct3)
      3'b000: begin
        legal    = 1'b1;
        fmt_strb = 4'(4'b0001 << commit_addr[1:0]);
        fmt_data = {4{commit_data[7:0]}};
      end
      3'b001: begin
        legal    = !commit_addr[0];
        fmt_strb = commit_addr[1] ? 4'b1100 : 4'b0011;
        fmt_data = {2{commit_data[15:0]}};
      end
      3'b010: begin
        legal    = (commit_addr[1:0] == 2'b00);
        fmt_strb = 4'b1111;
        fmt_data = commit_data;
      end
      default: legal = 1'b0;
    endcase
  end

  // Walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = 32'h0;
    ld_fwd_strb = 4'b0000;
    idx         = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (ent_addr[idx] == ld_query_addr[31:2])) begin
        ld_fwd_hit  = 1'b1;
        ld_fwd_data = ent_wdata[idx];
        ld_fwd_strb = ent_wstrb[idx];
      end
    end
  end

  // Entry payload storage; validity is tracked separately
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail]  <= commit_addr[31:2];
      ent_wdata[tail] <= fmt_data;
      ent_wstrb[tail] <= fmt_strb;
      ent_tag[tail]   <= commit_inst_num;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      valid          <= '0;
      drain_done     <= 1'b0;
      drain_inst_num <= 32'h0;
      err_misalign   <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      drain_done <= pop;
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head]    <= 1'b0;
        head           <= head + PTR_W'(1);
        drain_inst_num <= ent_tag[head];
      end
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
      if (commit_valid && !legal)
        err_misalign <= 1'b1;
      if (commit_valid && legal && sb_full)
        err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_store_buffer.sv
// Directed bench for commit_store_buffer with a scoreboard-driven drain monitor.
module tb_commit_store_buffer;

  logic        clk, rst;
  logic        commit_valid;
  logic [31:0] commit_addr, commit_data, commit_inst_num;
  logic [2:0]  commit_funct3;
  logic        sb_full, sb_empty;
  logic [3:0]  sb_count;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        drain_done;
  logic [31:0] drain_inst_num;
  logic [31:0] ld_query_addr;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic [3:0]  ld_fwd_strb;
  logic        err_misalign, err_overflow;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tag_q[$];
  int tests = 0;
  int fails = 0;

  commit_store_buffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_addr(commit_addr), .commit_data(commit_data),
    .commit_funct3(commit_funct3), .commit_inst_num(commit_inst_num),
    .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .drain_done(drain_done), .drain_inst_num(drain_inst_num),
    .ld_query_addr(ld_query_addr), .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
    .ld_fwd_strb(ld_fwd_strb), .err_misalign(err_misalign), .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle commit; the expected drain entry is queued when the push should land
  task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                        input logic [31:0] tag, input logic [31:0] ew, input logic [3:0] es,
                        input bit exp_push);
    exp_t e;
    commit_valid    = 1'b1;
    commit_addr     = a;
    commit_data     = d;
    commit_funct3   = f3;
    commit_inst_num = tag;
    if (exp_push) begin
      e.addr = {a[31:2], 2'b00}; e.wdata = ew; e.strb = es; e.tag = tag;
      exp_q.push_back(e);
    end
    step();
    commit_valid = 1'b0;
  endtask

  task automatic drain_all(input string name);
    int n;
    n = 0;
    mem_ack = 1'b1;
    while (!sb_empty && n < 50) begin
      step();
      n++;
    end
    mem_ack = 1'b0;
    check({name, "_drained"}, 32'(sb_empty), 32'd1);
    step();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete();
    tag_q.delete();
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Monitor: checks each accepted memory write and each drain_done pulse in order
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req && mem_ack) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_mem_write: got addr 0x%08h expected none", mem_addr);
          end else begin
            e = exp_q.pop_front();
            check("mem_addr", mem_addr, e.addr);
            check("mem_wdata", mem_wdata, e.wdata);
            check("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
            tag_q.push_back(e.tag);
          end
        end
        if (drain_done) begin
          if (tag_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_drain_done: got tag 0x%08h expected none", drain_inst_num);
          end else
            check("drain_inst_num", drain_inst_num, tag_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    commit_valid = 0; commit_addr = 0; commit_data = 0; commit_funct3 = 0;
    commit_inst_num = 0; mem_ack = 0; ld_query_addr = 0;
    do_reset(2);

    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_empty", 32'(sb_empty), 1);
    check("rst_full", 32'(sb_full), 0);
    check("rst_count", 32'(sb_count), 0);
    check("rst_drain_done", 32'(drain_done), 0);
    check("rst_drain_tag", drain_inst_num, 0);
    check("rst_fwd_hit", 32'(ld_fwd_hit), 0);
    check("rst_errs", {30'h0, err_misalign, err_overflow}, 0);

    // Single SW, acked two cycles after it appears
    commit(32'h100, 32'hDEADBEEF, 3'b010, 32'd1, 32'hDEADBEEF, 4'b1111, 1);
    check("sw_mem_req", 32'(mem_req), 1);
    check("sw_mem_addr", mem_addr, 32'h100);
    check("sw_count", 32'(sb_count), 1);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sw_drain_pulse", 32'(drain_done), 1);
    check("sw_empty", 32'(sb_empty), 1);
    step();
    check("sw_pulse_once", 32'(drain_done), 0);

    // Byte/half lanes and a misaligned half
    commit(32'h203, 32'h0000005A, 3'b000, 32'd2, 32'h5A5A5A5A, 4'b1000, 1);
    commit(32'h202, 32'h00001234, 3'b001, 32'd3, 32'h12341234, 4'b1100, 1);
    commit(32'h201, 32'h00005678, 3'b001, 32'd4, 32'h0, 4'b0, 0);
    check("sh_misalign_err", 32'(err_misalign), 1);
    check("sh_misalign_count", 32'(sb_count), 2);
    ld_query_addr = 32'h200;
    #1;
    check("lane_fwd_hit", 32'(ld_fwd_hit), 1);
    check("lane_fwd_data", ld_fwd_data, 32'h12341234);
    check("lane_fwd_strb", 32'(ld_fwd_strb), 32'hC);
    drain_all("lanes");

    // Fill to full, overflow, then drain back-to-back
    for (int i = 0; i < 8; i++)
      commit(32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 3'b010, 32'd10 + 32'(i),
             32'h1000 + 32'(i), 4'b1111, 1);
    check("fill_full", 32'(sb_full), 1);
    check("fill_count", 32'(sb_count), 8);
    commit(32'h500, 32'hBAD0BAD0, 3'b010, 32'd99, 32'h0, 4'b0, 0);
    check("overflow_err", 32'(err_overflow), 1);
    check("overflow_count", 32'(sb_count), 8);
    n = 0;
    mem_ack = 1'b1;
    while (!sb_empty && n < 20) begin
      step();
      n++;
    end
    mem_ack = 1'b0;
    check("full_drain_cycles", 32'(n), 8);
    step();
    step();

    // Continuous stream with ack held high, crossing pointer wrap
    do_reset(1);
    mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      commit_valid    = 1'b1;
      commit_addr     = 32'h600 + 32'(4 * i);
      commit_data     = 32'hC0DE0000 + 32'(i);
      commit_funct3   = 3'b010;
      commit_inst_num = 32'd100 + 32'(i);
      e.addr = 32'h600 + 32'(4 * i); e.wdata = 32'hC0DE0000 + 32'(i);
      e.strb = 4'b1111; e.tag = 32'd100 + 32'(i);
      exp_q.push_back(e);
      step();
      check("stream_count", 32'(sb_count), 1);
    end
    commit_valid = 1'b0;
    drain_all("stream");
    check("stream_errs", {30'h0, err_misalign, err_overflow}, 0);

    // Youngest-match forwarding
    commit(32'h300, 32'h11111111, 3'b010, 32'd50, 32'h11111111, 4'b1111, 1);
    commit(32'h301, 32'h000000AB, 3'b000, 32'd51, 32'hABABABAB, 4'b0010, 1);
    ld_query_addr = 32'h300;
    #1;
    check("fwd_hit", 32'(ld_fwd_hit), 1);
    check("fwd_strb", 32'(ld_fwd_strb), 32'h2);
    check("fwd_data", ld_fwd_data, 32'hABABABAB);
    ld_query_addr = 32'h304;
    #1;
    check("fwd_miss_hit", 32'(ld_fwd_hit), 0);
    check("fwd_miss_data", ld_fwd_data, 0);
    check("fwd_miss_strb", 32'(ld_fwd_strb), 0);
    drain_all("fwd");
    ld_query_addr = 32'h300;
    #1;
    check("fwd_after_drain", 32'(ld_fwd_hit), 0);

    // Reset with stores pending
    for (int i = 0; i < 3; i++)
      commit(32'h700 + 32'(4 * i), 32'h7000 + 32'(i), 3'b010, 32'd200 + 32'(i),
             32'h7000 + 32'(i), 4'b1111, 1);
    commit(32'h001, 32'h0, 3'b010, 32'd300, 32'h0, 4'b0, 0);
    check("pre_rst_req", 32'(mem_req), 1);
    check("pre_rst_count", 32'(sb_count), 3);
    do_reset(1);
    check("post_rst_req", 32'(mem_req), 0);
    check("post_rst_empty", 32'(sb_empty), 1);
    check("post_rst_errs", {30'h0, err_misalign, err_overflow}, 0);
    check("post_rst_drain", 32'(drain_done), 0);
    mem_ack = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_no_pulse", 32'(drain_done), 0);
    end
    mem_ack = 1'b0;

    check("exp_q_empty", 32'(exp_q.size()), 0);
    check("tag_q_empty", 32'(tag_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/commit_store_buffer.md
Name: commit_store_buffer

Overview:
Sits downstream of the ROB commit port and consumes retired stores. The ROB commit outputs are the MemWrite flag, address, value, funct3 and inst_num. Each retired store is queued in a FIFO of committed stores and drained to data memory over a req/ack handshake. The block supplies youngest-match store-to-load forwarding for the load unit and back-pressures the ROB when full. Stores accepted here are architecturally committed: no flush, no exception squash.

Parameters:
DEPTH, 8, number of buffer entries (power of 2, >=2)
PTR_W, 3, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
commit_valid  in  1  ROB out_MemWrite; store retires this cycle
commit_addr  in  32  byte address of store
commit_data  in  32  store value (low bits significant for SB/SH)
commit_funct3  in  3  000 SB, 001 SH, 010 SW
commit_inst_num  in  32  instruction tag of store
sb_full  out  1  buffer full; ROB must not retire a store
sb_empty  out  1  no pending stores
sb_count  out  PTR_W+1  occupancy
mem_req  out  1  write request to data memory
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  lane-aligned write data
mem_wstrb  out  4  byte enables
mem_ack  in  1  memory accepted current request
drain_done  out  1  one-cycle pulse: a store finished draining
drain_inst_num  out  32  tag of drained store, valid with drain_done
ld_query_addr  in  32  load address for forwarding lookup
ld_fwd_hit  out  1  some pending entry matches ld_query_addr[31:2]
ld_fwd_data  out  32  youngest matching entry wdata
ld_fwd_strb  out  4  youngest matching entry wstrb
err_misalign  out  1  sticky: misaligned or illegal-funct3 store dropped
err_overflow  out  1  sticky: push while full, dropped

Behaviour:
- Reset: head=tail=count=0 and all entries invalid. mem_req=0, sb_empty=1, sb_full=0, sb_count=0, drain_done=0, drain_inst_num=0, ld_fwd_hit=0, err_* = 0.
- Reset mid-handshake: pending stores are discarded. mem_req is low in the cycle after the reset edge.
- Push: on a clk edge with commit_valid=1, legal, and !sb_full, write entry[tail] = {addr, wdata, wstrb, inst_num} and increment tail mod DEPTH.
- Lane formatting at push:
  - SB: wstrb = 1<<addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: addr[0] must be 0; wstrb = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - SW: addr[1:0] must be 00; wstrb = 1111; wdata = data.
- Illegal push: misaligned, or funct3 not in {000, 001, 010}. No entry is written and err_misalign sets. Only rst clears it.
- Push while full: dropped, err_overflow sets. Only rst clears it.
- sb_full = (count==DEPTH) and sb_empty = (count==0), both combinational from registered count.
- Drain: mem_req = !sb_empty. mem_addr, mem_wdata and mem_wstrb are driven combinationally from entry[head]. They stay stable while mem_req=1 and mem_ack=0.
- A store pushed at edge N (buffer empty) raises mem_req in the cycle after edge N; minimum latency is 1 cycle.
- Pop: on an edge with mem_req=1 and mem_ack=1, increment head mod DEPTH. The next entry is presented in the following cycle; back-to-back acks drain one store per cycle.
- drain_done is registered: it pulses high for exactly one cycle after each pop edge, with drain_inst_num = popped tag.
- mem_ack while mem_req=0 is ignored.
- Simultaneous push and pop (not full): both occur and count is unchanged.
- When full, a pop and a push on the same edge: the push is still rejected, because sb_full is sampled pre-edge, and err_overflow sets.
- Pointer wrap: head and tail wrap DEPTH-1 to 0; count distinguishes full from empty.
- Forwarding is combinational over valid entries only:
  - A match is entry.addr[31:2] == ld_query_addr[31:2].
  - The youngest match is the one nearest to tail-1 going backwards.
  - No byte merging across entries. With no match: hit=0, data=0, strb=0.
  - The entry being popped this cycle is still visible until the edge.
- No flush or exception input: an ROB exception does not affect buffered stores.

Test Plan:
- Reset then single SW: commit addr=0x100, data=0xDEADBEEF, f3=010 → next cycle mem_req=1, mem_addr=0x100, wdata=0xDEADBEEF, wstrb=1111; ack 2 cycles later → drain_done pulse with the tag, sb_empty=1.
- SB/SH lanes: SB addr=0x203 data=0x5A → wstrb=1000, wdata=0x5A5A5A5A; SH addr=0x202 data=0x1234 → wstrb=1100, wdata=0x12341234; SH addr=0x201 → no entry, err_misalign=1.
- Fill to full: 8 SWs with mem_ack=0 → sb_full=1, count=8; 9th push → dropped, err_overflow=1; then hold ack=1 → 8 consecutive drain_done pulses in order, tags in order, 8 cycles.
- Wrap and concurrency: a continuous push stream with ack=1 every cycle for 20 stores → count stays at 1, FIFO order is preserved across pointer wrap, no errors.
- Forwarding: push SW 0x300=0x11111111 then SB 0x301=0xAB; query 0x300 → hit=1, strb=0010, data=0xABABABAB; query 0x304 → hit=0.
- Reset mid-operation: 3 entries pending with mem_req=1, assert rst one cycle → mem_req=0, sb_empty=1, err flags 0, no drain_done pulse.
